reg_target_sequencer: RTL and testbench

- Register-bus slave that sequences target power and target nRST for a clean target restart: power-off, then reset hold, then settle.
- Sits beside reg_chipwhisperer on the shared register bus. Read data and hyplen are OR-combined with the other slaves.
- Its power/nRST outputs are ORed/muxed into the top-level target_npower and target_nRST drive logic.
- Also produces a capture/glitch arm-inhibit while a sequence runs.

---
 rtl/reg_target_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_reg_target_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_target_sequencer.sv
// Register-bus slave that sequences target power and nRST (power-off, reset hold, settle)
// for a clean target restart, and inhibits capture/glitch arming while a sequence runs.
module reg_target_sequencer #(
   parameter logic [5:0]  ADDR_SEQ   = 6'd55,
   parameter int          CNT_WIDTH  = 16,
   parameter logic [15:0] DEF_OFF    = 16'd1000,
   parameter logic [15:0] DEF_RST    = 16'd100,
   parameter logic [15:0] DEF_SETTLE = 16'd100
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [5:0]  reg_address,
   input  logic [15:0] reg_bytecnt,
   input  logic [7:0]  reg_datai,
   output logic [7:0]  reg_datao,
   input  logic        reg_read,
   input  logic        reg_write,
   input  logic        reg_addrvalid,
   input  logic [5:0]  reg_hypaddress,
   output logic [15:0] reg_hyplen,
   output logic        targetpower_off,
   output logic        enable_output_nrst,
   output logic        output_nrst,
   output logic        seq_busy,
   output logic        arm_inhibit,
   output logic        seq_done
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PWR_OFF  = 3'd1,
      S_RST_HOLD = 3'd2,
      S_SETTLE   = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [15:0]           off_q, off_d;
   logic [15:0]           rst_q, rst_d;
   logic [15:0]           settle_q, settle_d;
   logic [15:0]           snap_rst_q, snap_rst_d;
   logic [15:0]           snap_settle_q, snap_settle_d;
   logic                  done_sticky_q, done_sticky_d;
   logic                  pwr_off_q, pwr_off_d;
   logic                  nrst_en_q, nrst_en_d;
   logic                  nrst_lvl_q, nrst_lvl_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic sel, wr_en, wr_ctrl;

   assign sel     = reg_addrvalid && (reg_address == ADDR_SEQ);
   assign wr_en   = sel && reg_write;
   assign wr_ctrl = wr_en && (reg_bytecnt == 16'd0);

   // A zero-length phase still lasts one cycle so every phase is observable.
   function automatic logic [CNT_WIDTH-1:0] load_val(input logic [15:0] n);
      return (n == 16'd0) ? CNT_WIDTH'(1) : CNT_WIDTH'(n);
   endfunction

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      off_d         = off_q;
      rst_d         = rst_q;
      settle_d      = settle_q;
      snap_rst_d    = snap_rst_q;
      snap_settle_d = snap_settle_q;
      done_sticky_d = done_sticky_q;

      if (wr_en) begin
         case (reg_bytecnt)
            16'd1:   off_d[7:0]     = reg_datai;
            16'd2:   off_d[15:8]    = reg_datai;
            16'd3:   rst_d[7:0]     = reg_datai;
            16'd4:   rst_d[15:8]    = reg_datai;
            16'd5:   settle_d[7:0]  = reg_datai;
            16'd6:   settle_d[15:8] = reg_datai;
            default: ;
         endcase
      end

      // Abort wins over everything, including a start in the same write.
      if (wr_ctrl && reg_datai[1]) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (wr_ctrl && reg_datai[0]) begin
                  snap_rst_d    = rst_q;
                  snap_settle_d = settle_q;
                  done_sticky_d = 1'b0;
                  if (reg_datai[2]) begin
                     state_d = S_RST_HOLD;
                     cnt_d   = load_val(rst_q);
                  end else begin
                     state_d = S_PWR_OFF;
                     cnt_d   = load_val(off_q);
                  end
               end
            end
            S_PWR_OFF: begin
               if (cnt_q == CNT_WIDTH'(1)) begin
                  state_d = S_RST_HOLD;
                  cnt_d   = load_val(snap_rst_q);
               end else begin
                  cnt_d = cnt_q - CNT_WIDTH'(1);
               end
            end
            S_RST_HOLD: begin
               if (cnt_q == CNT_WIDTH'(1)) begin
                  state_d = S_SETTLE;
                  cnt_d   = load_val(snap_settle_q);
               end else begin
                  cnt_d = cnt_q - CNT_WIDTH'(1);
               end
            end
            S_SETTLE: begin
               if (cnt_q == CNT_WIDTH'(1)) begin
                  state_d       = S_DONE;
                  done_sticky_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - CNT_WIDTH'(1);
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end

      // Outputs are decoded from the next state so the registered copies track state_q exactly.
      pwr_off_d  = 1'b0;
      nrst_en_d  = 1'b0;
      nrst_lvl_d = 1'b1;
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      case (state_d)
         S_PWR_OFF: begin
            pwr_off_d  = 1'b1;
            nrst_en_d  = 1'b1;
            nrst_lvl_d = 1'b0;
         end
         S_RST_HOLD: begin
            nrst_en_d  = 1'b1;
            nrst_lvl_d = 1'b0;
         end
         S_SETTLE: nrst_en_d = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         off_q         <= DEF_OFF;
         rst_q         <= DEF_RST;
         settle_q      <= DEF_SETTLE;
         snap_rst_q    <= DEF_RST;
         snap_settle_q <= DEF_SETTLE;
         done_sticky_q <= 1'b0;
         pwr_off_q     <= 1'b0;
         nrst_en_q     <= 1'b0;
         nrst_lvl_q    <= 1'b1;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         off_q         <= off_d;
         rst_q         <= rst_d;
         settle_q      <= settle_d;
         snap_rst_q    <= snap_rst_d;
         snap_settle_q <= snap_settle_d;
         done_sticky_q <= done_sticky_d;
         pwr_off_q     <= pwr_off_d;
         nrst_en_q     <= nrst_en_d;
         nrst_lvl_q    <= nrst_lvl_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   always_comb begin
      reg_datao = 8'h00;
      if (sel && reg_read) begin
         case (reg_bytecnt)
            16'd0:   reg_datao = {3'b000, state_q, done_sticky_q, busy_q};
            16'd1:   reg_datao = off_q[7:0];
            16'd2:   reg_datao = off_q[15:8];
            16'd3:   reg_datao = rst_q[7:0];
            16'd4:   reg_datao = rst_q[15:8];
            16'd5:   reg_datao = settle_q[7:0];
            16'd6:   reg_datao = settle_q[15:8];
            default: reg_datao = 8'h00;
         endcase
      end
   end

   assign reg_hyplen         = (reg_hypaddress == ADDR_SEQ) ? 16'd7 : 16'd0;
   assign targetpower_off    = pwr_off_q;
   assign enable_output_nrst = nrst_en_q;
   assign output_nrst        = nrst_lvl_q;
   assign seq_busy           = busy_q;
   assign arm_inhibit        = busy_q;
   assign seq_done           = done_q;

endmodule

// File: tb/tb_reg_target_sequencer.sv
// Directed bench for reg_target_sequencer: per-cycle expected output vectors and read data
// are queued by a small phase model and popped/compared as the DUT produces them.
module tb_reg_target_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [5:0]  reg_address;
   logic [15:0] reg_bytecnt;
   logic [7:0]  reg_datai;
   logic [7:0]  reg_datao;
   logic        reg_read;
   logic        reg_write;
   logic        reg_addrvalid;
   logic [5:0]  reg_hypaddress;
   logic [15:0] reg_hyplen;
   logic        targetpower_off;
   logic        enable_output_nrst;
   logic        output_nrst;
   logic        seq_busy;
   logic        arm_inhibit;
   logic        seq_done;

   int errors = 0;
   int checks = 0;

   // Vector order: {targetpower_off, enable_output_nrst, output_nrst, seq_busy, seq_done}
   localparam logic [4:0] V_IDLE   = 5'b00100;
   localparam logic [4:0] V_PWR    = 5'b11010;
   localparam logic [4:0] V_RST    = 5'b01010;
   localparam logic [4:0] V_SETTLE = 5'b01110;
   localparam logic [4:0] V_DONE   = 5'b00011;
   localparam logic [4:0] M_ALL    = 5'b11111;
   localparam logic [4:0] M_DONE   = 5'b11011;

   typedef struct {
      string      tag;
      logic [4:0] exp;
      logic [4:0] mask;
   } outExp_t;

   typedef struct {
      string      tag;
      logic [15:0] exp;
   } rdExp_t;

   outExp_t outQ[$];
   rdExp_t  rdQ[$];

   reg_target_sequencer dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .reg_address        (reg_address),
      .reg_bytecnt        (reg_bytecnt),
      .reg_datai          (reg_datai),
      .reg_datao          (reg_datao),
      .reg_read           (reg_read),
      .reg_write          (reg_write),
      .reg_addrvalid      (reg_addrvalid),
      .reg_hypaddress     (reg_hypaddress),
      .reg_hyplen         (reg_hyplen),
      .targetpower_off    (targetpower_off),
      .enable_output_nrst (enable_output_nrst),
      .output_nrst        (output_nrst),
      .seq_busy           (seq_busy),
      .arm_inhibit        (arm_inhibit),
      .seq_done           (seq_done)
   );

   always #5 clk = ~clk;

   // Watchdog so a stuck run still reports before stopping.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic pushPhase(input string tag, input logic [4:0] v, input logic [4:0] m, input int n);
      for (int i = 0; i < n; i++) outQ.push_back('{tag, v, m});
   endtask

   // Expected trace of one complete sequence followed by one idle cycle.
   task automatic genSeq(input int offN, input int rstN, input int settleN, input bit skip);
      if (!skip) pushPhase("pwr_off", V_PWR, M_ALL, (offN == 0) ? 1 : offN);
      pushPhase("rst_hold", V_RST, M_ALL, (rstN == 0) ? 1 : rstN);
      pushPhase("settle", V_SETTLE, M_ALL, (settleN == 0) ? 1 : settleN);
      pushPhase("done", V_DONE, M_DONE, 1);
      pushPhase("idle_after", V_IDLE, M_ALL, 1);
   endtask

   task automatic checkOutput();
      outExp_t    e;
      logic [4:0] obs;
      if (outQ.size() == 0) begin
         checks++;
         errors++;
         $error("[TB] FAIL scoreboard_underflow observed=empty expected=entry");
         return;
      end
      e   = outQ.pop_front();
      obs = {targetpower_off, enable_output_nrst, output_nrst, seq_busy, seq_done};
      checks++;
      assert ((obs & e.mask) === (e.exp & e.mask))
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%b expected=%b", e.tag, obs & e.mask, e.exp & e.mask);
      end
      checks++;
      assert (arm_inhibit === seq_busy)
      else begin
         errors++;
         $error("[TB] FAIL %s_arm_inhibit observed=%b expected=%b", e.tag, arm_inhibit, seq_busy);
      end
   endtask

   task automatic runTrace(input int n);
      for (int i = 0; i < n; i++) begin
         checkOutput();
         @(negedge clk);
      end
   endtask

   // Called at a negedge: presents one write for exactly one clock edge.
   task automatic applyStimulus(input logic [5:0] addr, input logic [15:0] bytecnt, input logic [7:0] data);
      reg_address   = addr;
      reg_bytecnt   = bytecnt;
      reg_datai     = data;
      reg_write     = 1'b1;
      reg_addrvalid = 1'b1;
      @(negedge clk);
      reg_write     = 1'b0;
      reg_addrvalid = 1'b0;
   endtask

   task automatic setTimes(input logic [15:0] offN, input logic [15:0] rstN, input logic [15:0] settleN);
      applyStimulus(6'd55, 16'd1, offN[7:0]);
      applyStimulus(6'd55, 16'd2, offN[15:8]);
      applyStimulus(6'd55, 16'd3, rstN[7:0]);
      applyStimulus(6'd55, 16'd4, rstN[15:8]);
      applyStimulus(6'd55, 16'd5, settleN[7:0]);
      applyStimulus(6'd55, 16'd6, settleN[15:8]);
   endtask

   task automatic readCheck(input string tag, input logic [5:0] addr, input logic valid,
                            input logic [15:0] bytecnt, input logic [7:0] exp);
      rdExp_t e;
      rdQ.push_back('{tag, {8'h00, exp}});
      reg_address   = addr;
      reg_bytecnt   = bytecnt;
      reg_read      = 1'b1;
      reg_addrvalid = valid;
      #1;
      e = rdQ.pop_front();
      checks++;
      assert ({8'h00, reg_datao} === e.exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", e.tag, reg_datao, e.exp[7:0]);
      end
      reg_read      = 1'b0;
      reg_addrvalid = 1'b0;
   endtask

   task automatic hyplenCheck(input string tag, input logic [5:0] addr, input logic [15:0] exp);
      rdExp_t e;
      rdQ.push_back('{tag, exp});
      reg_hypaddress = addr;
      #1;
      e = rdQ.pop_front();
      checks++;
      assert (reg_hyplen === e.exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", e.tag, reg_hyplen, e.exp);
      end
   endtask

   initial begin
      reset_n        = 1'b0;
      reg_address    = 6'd0;
      reg_bytecnt    = 16'd0;
      reg_datai      = 8'd0;
      reg_read       = 1'b0;
      reg_write      = 1'b0;
      reg_addrvalid  = 1'b0;
      reg_hypaddress = 6'd0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Reset values
      pushPhase("reset_outputs", V_IDLE, M_ALL, 1);
      runTrace(1);
      readCheck("reset_status", 6'd55, 1'b1, 16'd0, 8'h00);
      readCheck("reset_off_lo", 6'd55, 1'b1, 16'd1, 8'hE8);
      readCheck("reset_off_hi", 6'd55, 1'b1, 16'd2, 8'h03);
      readCheck("reset_rst_lo", 6'd55, 1'b1, 16'd3, 8'h64);
      readCheck("reset_rst_hi", 6'd55, 1'b1, 16'd4, 8'h00);
      readCheck("reset_settle_lo", 6'd55, 1'b1, 16'd5, 8'h64);
      readCheck("reset_settle_hi", 6'd55, 1'b1, 16'd6, 8'h00);
      @(negedge clk);

      // Full sequence 5/3/2: 11 busy cycles, one done pulse
      setTimes(16'd5, 16'd3, 16'd2);
      readCheck("full_off_readback", 6'd55, 1'b1, 16'd1, 8'h05);
      @(negedge clk);
      applyStimulus(6'd55, 16'd0, 8'h01);
      genSeq(5, 3, 2, 1'b0);
      runTrace(5 + 3 + 2 + 1 + 1);
      readCheck("full_status", 6'd55, 1'b1, 16'd0, 8'h02);
      @(negedge clk);

      // Skip power with zero rst/settle: each phase clamps to one cycle
      setTimes(16'd5, 16'd0, 16'd0);
      applyStimulus(6'd55, 16'd0, 8'h05);
      genSeq(5, 0, 0, 1'b1);
      runTrace(1 + 1 + 1 + 1);
      readCheck("skip_status", 6'd55, 1'b1, 16'd0, 8'h02);
      @(negedge clk);

      // Abort during cycle 2 of a 5-cycle power-off
      setTimes(16'd5, 16'd3, 16'd2);
      applyStimulus(6'd55, 16'd0, 8'h01);
      pushPhase("abort_pwr", V_PWR, M_ALL, 2);
      checkOutput();
      readCheck("abort_status_busy", 6'd55, 1'b1, 16'd0, 8'h05);
      @(negedge clk);
      checkOutput();
      applyStimulus(6'd55, 16'd0, 8'h02);
      pushPhase("abort_idle", V_IDLE, M_ALL, 4);
      runTrace(4);
      readCheck("abort_status", 6'd55, 1'b1, 16'd0, 8'h00);

      // Bus isolation
      readCheck("iso_wrong_addr", 6'd54, 1'b1, 16'd1, 8'h00);
      readCheck("iso_no_valid", 6'd55, 1'b0, 16'd1, 8'h00);
      readCheck("iso_byte7", 6'd55, 1'b1, 16'd7, 8'h00);
      hyplenCheck("hyplen_other", 6'd54, 16'd0);
      hyplenCheck("hyplen_match", 6'd55, 16'd7);
      @(negedge clk);
      applyStimulus(6'd54, 16'd0, 8'h01);
      applyStimulus(6'd54, 16'd1, 8'h11);
      applyStimulus(6'd55, 16'd7, 8'hFF);
      pushPhase("iso_no_start", V_IDLE, M_ALL, 2);
      runTrace(2);
      readCheck("iso_off_kept", 6'd55, 1'b1, 16'd1, 8'h05);
      @(negedge clk);

      // Snapshot: rewriting rst and restarting during RST_HOLD changes nothing now
      setTimes(16'd2, 16'd4, 16'd1);
      applyStimulus(6'd55, 16'd0, 8'h01);
      genSeq(2, 4, 1, 1'b0);
      runTrace(2);
      checkOutput();
      applyStimulus(6'd55, 16'd3, 8'd50);
      checkOutput();
      applyStimulus(6'd55, 16'd4, 8'd0);
      checkOutput();
      applyStimulus(6'd55, 16'd0, 8'h01);
      runTrace(1 + 1 + 1 + 1);
      readCheck("snap_rst_reg", 6'd55, 1'b1, 16'd3, 8'd50);
      @(negedge clk);
      applyStimulus(6'd55, 16'd0, 8'h05);
      genSeq(0, 50, 1, 1'b1);
      runTrace(50 + 1 + 1 + 1);

      // Asynchronous reset in the middle of SETTLE
      setTimes(16'd5, 16'd2, 16'd20);
      applyStimulus(6'd55, 16'd0, 8'h05);
      pushPhase("pre_reset_rst", V_RST, M_ALL, 2);
      pushPhase("pre_reset_settle", V_SETTLE, M_ALL, 3);
      runTrace(5);
      #2;
      reset_n = 1'b0;
      #1;
      pushPhase("async_reset", V_IDLE, M_ALL, 1);
      checkOutput();
      readCheck("async_reset_status", 6'd55, 1'b1, 16'd0, 8'h00);
      readCheck("async_reset_off", 6'd55, 1'b1, 16'd1, 8'hE8);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      pushPhase("post_reset", V_IDLE, M_ALL, 2);
      runTrace(2);

      checks++;
      assert (outQ.size() === 0)
      else begin
         errors++;
         $error("[TB] FAIL scoreboard_leftover observed=%0d expected=0", outQ.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
